// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, fetches the whole block one word per cycle,
// streams each returned word into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  localparam int WW = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          miss_detected,
  input  logic [15:0]   miss_address,
  input  logic [15:0]   memory_data,
  input  logic          memory_data_valid,
  output logic          fsm_busy,
  output logic          memory_read,
  output logic [15:0]   memory_address,
  output logic          write_data_array,
  output logic [WW-1:0] fill_word,
  output logic          write_tag_array
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t         r_state, w_state;
  logic [15:WW+1] r_blk, w_blk;
  logic [WW:0]    r_issue, w_issue;
  logic [WW-1:0]  r_recv, w_recv;
  logic           w_unused;
  // data goes straight to the cache; block offset bits of the miss are dropped
  assign w_unused = ^{memory_data, miss_address[WW:0]};
  assign fsm_busy = r_state == FILL;
  // issue count has reached BLOCK_WORDS exactly when its top bit is set
  assign memory_read = fsm_busy & ~r_issue[WW];
  assign memory_address = memory_read ? {r_blk, r_issue[WW-1:0], 1'b0} : '0;
  assign write_data_array = fsm_busy & memory_data_valid;
  assign fill_word = fsm_busy ? r_recv : '0;
  assign write_tag_array = write_data_array & (&r_recv);
  always_comb begin
    w_state = r_state;
    w_blk = r_blk;
    w_issue = r_issue + (WW+1)'(memory_read);
    w_recv = r_recv + WW'(write_data_array);
    if (r_state == IDLE && miss_detected) begin
      w_state = FILL;
      w_blk = miss_address[15:WW+1];
      w_issue = '0;
      w_recv = '0;
    end
    if (write_tag_array) w_state = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_blk <= '0;
      r_issue <= '0;
      r_recv <= '0;
    end else begin
      r_state <= w_state;
      r_blk <= w_blk;
      r_issue <= w_issue;
      r_recv <= w_recv;
    end
  end
endmodule
